// File: rtl/alu_share_pkg.sv
// Shared types, opcode/funct constants and the supported-operation decoder
// for the ALU sharing controller.
package alu_share_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_RESPOND = 2'd3
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0a;
    localparam logic [5:0] OP_SLTIU = 6'h0b;
    localparam logic [5:0] OP_ANDI  = 6'h12;
    localparam logic [5:0] OP_ORI   = 6'h13;
    localparam logic [5:0] OP_XORI  = 6'h15;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_LBU   = 6'h24;
    localparam logic [5:0] OP_LHU   = 6'h25;
    localparam logic [5:0] OP_SB    = 6'h28;
    localparam logic [5:0] OP_SH    = 6'h29;
    localparam logic [5:0] OP_SW    = 6'h2b;
    localparam logic [5:0] OP_LL    = 6'h30;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2a;
    localparam logic [5:0] FN_SLTU = 6'h2b;

    function automatic logic alu_op_supported(input logic [5:0] opcode, input logic [5:0] funct);
        logic ok;
        ok = 1'b0;
        if (opcode == OP_RTYPE) begin
            case (funct)
                FN_SLL, FN_SRL, FN_SRA, FN_ADD, FN_ADDU, FN_SUB, FN_SUBU,
                FN_AND, FN_OR, FN_NOR, FN_SLT, FN_SLTU: ok = 1'b1;
                default: ok = 1'b0;
            endcase
        end else begin
            case (opcode)
                OP_BEQ, OP_BNE, OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI,
                OP_ORI, OP_XORI, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW,
                OP_LL: ok = 1'b1;
                default: ok = 1'b0;
            endcase
        end
        return ok;
    endfunction

endpackage

// File: rtl/ALU32bit.sv
// Unclocked 32-bit MIPS-style ALU; branch_sig is the zero flag (inverted for BNE).
module ALU32bit
    import alu_share_pkg::*;
(
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic [4:0]  shamt,
    input  logic [15:0] imm,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    output logic [31:0] ALU_result,
    output logic        branch_sig
);

    logic [31:0] imm_sext_s;
    logic [31:0] imm_zext_s;

    assign imm_sext_s = {{16{imm[15]}}, imm};
    assign imm_zext_s = {16'h0000, imm};

    // Operation select and branch flag.
    always_comb begin
        ALU_result = 32'h0000_0000;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_SLL:          ALU_result = rt << shamt;
                    FN_SRL:          ALU_result = rt >> shamt;
                    FN_SRA:          ALU_result = $signed(rt) >>> shamt;
                    FN_ADD, FN_ADDU: ALU_result = rs + rt;
                    FN_SUB, FN_SUBU: ALU_result = rs - rt;
                    FN_AND:          ALU_result = rs & rt;
                    FN_OR:           ALU_result = rs | rt;
                    FN_XOR:          ALU_result = rs ^ rt;
                    FN_NOR:          ALU_result = ~(rs | rt);
                    FN_SLT:          ALU_result = {31'h0, $signed(rs) < $signed(rt)};
                    FN_SLTU:         ALU_result = {31'h0, rs < rt};
                    default:         ALU_result = 32'h0000_0000;
                endcase
            end
            OP_BEQ, OP_BNE: ALU_result = rs - rt;
            OP_ADDI, OP_ADDIU, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW, OP_LL:
                ALU_result = rs + imm_sext_s;
            OP_SLTI:  ALU_result = {31'h0, $signed(rs) < $signed(imm_sext_s)};
            OP_SLTIU: ALU_result = {31'h0, rs < imm_sext_s};
            OP_ANDI:  ALU_result = rs & imm_zext_s;
            OP_ORI:   ALU_result = rs | imm_zext_s;
            OP_XORI:  ALU_result = rs ^ imm_zext_s;
            default:  ALU_result = 32'h0000_0000;
        endcase
        if (opcode == OP_BNE) begin
            branch_sig = (ALU_result != 32'h0000_0000);
        end else begin
            branch_sig = (ALU_result == 32'h0000_0000);
        end
    end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first requester at
// or after ptr, wrapping around.
module rr_arbiter #(
    parameter int N = 2,
    parameter int W = 1
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] gnt,
    output logic         any
);

    // Walk the requesters in priority order; the first hit wins.
    always_comb begin
        logic found_s;
        int   idx_s;
        gnt     = {N{1'b0}};
        found_s = 1'b0;
        for (int i = 0; i < N; i++) begin
            idx_s      = (int'(ptr) + i) % N;
            gnt[idx_s] = req[idx_s] & ~found_s;
            found_s    = found_s | req[idx_s];
        end
        any = |req;
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// Round-robin sharing of one ALU32bit between NUM_REQ requesters: one
// transaction in flight, operands held constant while the ALU settles.
module alu_share_ctrl
    import alu_share_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDW     = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [6*NUM_REQ-1:0]  req_opcode,
    input  logic [6*NUM_REQ-1:0]  req_funct,
    input  logic [5*NUM_REQ-1:0]  req_shamt,
    input  logic [16*NUM_REQ-1:0] req_imm,
    input  logic [32*NUM_REQ-1:0] req_rs,
    input  logic [32*NUM_REQ-1:0] req_rt,
    output logic [NUM_REQ-1:0]    rsp_valid,
    input  logic [NUM_REQ-1:0]    rsp_ready,
    output logic [31:0]           rsp_result,
    output logic                  rsp_branch,
    output logic                  rsp_illegal,
    output logic                  busy
);

    state_e               state_r, next_state_s;
    logic [IDW-1:0]       rr_ptr_r;
    logic [NUM_REQ-1:0]   gnt_s;
    logic                 any_s;
    logic [IDW-1:0]       gnt_idx_s;
    int                   sel_s;
    logic                 handshake_s;

    logic [5:0]           opcode_r, funct_r;
    logic [4:0]           shamt_r;
    logic [15:0]          imm_r;
    logic [31:0]          rs_r, rt_r;
    logic [IDW-1:0]       grant_r;

    logic [31:0]          alu_result_s;
    logic                 branch_s;
    logic                 supported_s;
    logic                 is_branch_op_s;

    logic [NUM_REQ-1:0]   rsp_valid_r;
    logic [31:0]          rsp_result_r;
    logic                 rsp_branch_r;
    logic                 rsp_illegal_r;

    rr_arbiter #(.N(NUM_REQ), .W(IDW)) u_arb (
        .req (req_valid),
        .ptr (rr_ptr_r),
        .gnt (gnt_s),
        .any (any_s)
    );

    ALU32bit u_alu (
        .opcode     (opcode_r),
        .funct      (funct_r),
        .shamt      (shamt_r),
        .imm        (imm_r),
        .rs         (rs_r),
        .rt         (rt_r),
        .ALU_result (alu_result_s),
        .branch_sig (branch_s)
    );

    // One-hot grant to index; the grant is one-hot so OR-ing is exact.
    always_comb begin
        gnt_idx_s = {IDW{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            gnt_idx_s = gnt_idx_s | (gnt_s[i] ? IDW'(i) : {IDW{1'b0}});
        end
        sel_s          = int'(gnt_idx_s);
        handshake_s    = (state_r == ST_IDLE) && any_s;
        supported_s    = alu_op_supported(opcode_r, funct_r);
        is_branch_op_s = (opcode_r == OP_BEQ) || (opcode_r == OP_BNE);
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (any_s) next_state_s = ST_ISSUE;
                else       next_state_s = ST_IDLE;
            end
            ST_ISSUE:   next_state_s = ST_CAPTURE;
            ST_CAPTURE: next_state_s = ST_RESPOND;
            ST_RESPOND: begin
                if (rsp_ready[grant_r]) next_state_s = ST_IDLE;
                else                    next_state_s = ST_RESPOND;
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Output decode: requester handshake is only offered in IDLE.
    always_comb begin
        if (state_r == ST_IDLE) begin
            req_ready = gnt_s;
            busy      = 1'b0;
        end else begin
            req_ready = {NUM_REQ{1'b0}};
            busy      = 1'b1;
        end
    end

    // Operand registers feed the ALU and only change on a grant.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            opcode_r <= 6'h00;
            funct_r  <= 6'h00;
            shamt_r  <= 5'h00;
            imm_r    <= 16'h0000;
            rs_r     <= 32'h0000_0000;
            rt_r     <= 32'h0000_0000;
            grant_r  <= {IDW{1'b0}};
            rr_ptr_r <= {IDW{1'b0}};
        end else if (handshake_s) begin
            opcode_r <= req_opcode[sel_s*6 +: 6];
            funct_r  <= req_funct[sel_s*6 +: 6];
            shamt_r  <= req_shamt[sel_s*5 +: 5];
            imm_r    <= req_imm[sel_s*16 +: 16];
            rs_r     <= req_rs[sel_s*32 +: 32];
            rt_r     <= req_rt[sel_s*32 +: 32];
            grant_r  <= gnt_idx_s;
            rr_ptr_r <= IDW'((sel_s + 1) % NUM_REQ);
        end
    end

    // Result capture with sanitising of unsupported ops and non-branch flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_valid_r   <= {NUM_REQ{1'b0}};
            rsp_result_r  <= 32'h0000_0000;
            rsp_branch_r  <= 1'b0;
            rsp_illegal_r <= 1'b0;
        end else if (state_r == ST_CAPTURE) begin
            rsp_valid_r   <= {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_r;
            rsp_result_r  <= supported_s ? alu_result_s : 32'h0000_0000;
            rsp_branch_r  <= supported_s && is_branch_op_s && branch_s;
            rsp_illegal_r <= ~supported_s;
        end else if ((state_r == ST_RESPOND) && rsp_ready[grant_r]) begin
            rsp_valid_r   <= {NUM_REQ{1'b0}};
        end
    end

    assign rsp_valid   = rsp_valid_r;
    assign rsp_result  = rsp_result_r;
    assign rsp_branch  = rsp_branch_r;
    assign rsp_illegal = rsp_illegal_r;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed plus randomized bench for alu_share_ctrl with two requesters,
// checked against an operation-level reference model.
module tb_alu_share_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
    logic [11:0] req_opcode, req_funct;
    logic [9:0]  req_shamt;
    logic [31:0] req_imm;
    logic [63:0] req_rs, req_rt;
    logic [31:0] rsp_result;
    logic        rsp_branch, rsp_illegal, busy;

    int checks   = 0;
    int failures = 0;
    int exp_ptr  = 0;

    always #5 clk = ~clk;

    alu_share_ctrl #(.NUM_REQ(2), .IDW(1)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_opcode (req_opcode),
        .req_funct  (req_funct),
        .req_shamt  (req_shamt),
        .req_imm    (req_imm),
        .req_rs     (req_rs),
        .req_rt     (req_rt),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_branch (rsp_branch),
        .rsp_illegal(rsp_illegal),
        .busy       (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: what the controller must return for one operation.
    function automatic void model(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] sh,
                                  input logic [15:0] imm, input logic [31:0] rs, input logic [31:0] rt,
                                  output logic [31:0] res, output logic br, output logic ill);
        logic [31:0] se, ze;
        se = {{16{imm[15]}}, imm};
        ze = {16'h0000, imm};
        res = 32'h0; br = 1'b0; ill = 1'b0;
        if (op == 6'h00) begin
            case (fn)
                6'h00: res = rt << sh;
                6'h02: res = rt >> sh;
                6'h03: res = $signed(rt) >>> sh;
                6'h20, 6'h21: res = rs + rt;
                6'h22, 6'h23: res = rs - rt;
                6'h24: res = rs & rt;
                6'h25: res = rs | rt;
                6'h27: res = ~(rs | rt);
                6'h2a: res = ($signed(rs) < $signed(rt)) ? 32'd1 : 32'd0;
                6'h2b: res = (rs < rt) ? 32'd1 : 32'd0;
                default: ill = 1'b1;
            endcase
        end else begin
            case (op)
                6'h04: begin res = rs - rt; br = (rs == rt); end
                6'h05: begin res = rs - rt; br = (rs != rt); end
                6'h08, 6'h09, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2b, 6'h30: res = rs + se;
                6'h0a: res = ($signed(rs) < $signed(se)) ? 32'd1 : 32'd0;
                6'h0b: res = (rs < se) ? 32'd1 : 32'd0;
                6'h12: res = rs & ze;
                6'h13: res = rs | ze;
                6'h15: res = rs ^ ze;
                default: ill = 1'b1;
            endcase
        end
    endfunction

    task automatic drive(input int r, input logic [5:0] op, input logic [5:0] fn, input logic [4:0] sh,
                         input logic [15:0] imm, input logic [31:0] rs, input logic [31:0] rt);
        req_opcode[r*6 +: 6]  = op;
        req_funct[r*6 +: 6]   = fn;
        req_shamt[r*5 +: 5]   = sh;
        req_imm[r*16 +: 16]   = imm;
        req_rs[r*32 +: 32]    = rs;
        req_rt[r*32 +: 32]    = rt;
    endtask

    // One full transaction from requester r, called on a negedge with DUT idle.
    task automatic run_txn(input string tag, input int r, input logic [5:0] op, input logic [5:0] fn,
                           input logic [4:0] sh, input logic [15:0] imm, input logic [31:0] rs,
                           input logic [31:0] rt, input int hold);
        logic [31:0] e_res;
        logic        e_br, e_ill;
        logic [1:0]  own;
        int          waited;
        model(op, fn, sh, imm, rs, rt, e_res, e_br, e_ill);
        own = 2'b01 << r;
        drive(r, op, fn, sh, imm, rs, rt);
        req_valid = own;
        rsp_ready = 2'b00;
        #1;
        waited = 0;
        while (req_ready !== own && waited < 20) begin
            @(negedge clk); #1; waited++;
        end
        check({tag, "_granted"}, {31'h0, waited < 20}, 32'd1);
        if (waited >= 20) begin
            req_valid = 2'b00;
            return;
        end
        exp_ptr = (r + 1) % 2;
        @(negedge clk);
        req_valid = 2'b00;
        #1;
        check({tag, "_issue_busy"}, {31'h0, busy}, 32'd1);
        check({tag, "_issue_rdy"}, {30'h0, req_ready | rsp_valid}, 32'd0);
        @(negedge clk); #1;
        check({tag, "_capture_valid"}, {30'h0, rsp_valid}, 32'd0);
        @(negedge clk); #1;
        check({tag, "_rsp_valid"}, {30'h0, rsp_valid}, {30'h0, own});
        check({tag, "_result"}, rsp_result, e_res);
        check({tag, "_branch"}, {31'h0, rsp_branch}, {31'h0, e_br});
        check({tag, "_illegal"}, {31'h0, rsp_illegal}, {31'h0, e_ill});
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            req_valid = 2'b11;
            rsp_ready = ~own;
            #1;
            check({tag, "_hold_rdy"}, {30'h0, req_ready}, 32'd0);
            check({tag, "_hold_valid"}, {30'h0, rsp_valid}, {30'h0, own});
            check({tag, "_hold_result"}, rsp_result, e_res);
        end
        req_valid = 2'b00;
        rsp_ready = own;
        @(negedge clk);
        rsp_ready = 2'b00;
        #1;
        check({tag, "_done_valid"}, {30'h0, rsp_valid}, 32'd0);
        check({tag, "_done_busy"}, {31'h0, busy}, 32'd0);
    endtask

    initial begin
        logic [5:0] ops[19];
        logic [5:0] fns[15];
        logic [5:0] op, fn;
        int last_cyc, ngrants, last_g, waited;

        ops = '{6'h00, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0a, 6'h0b, 6'h12, 6'h13, 6'h15,
                6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2b, 6'h30, 6'h0d, 6'h3f};
        fns = '{6'h00, 6'h02, 6'h03, 6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26,
                6'h27, 6'h2a, 6'h2b, 6'h3f, 6'h01};

        reset = 1'b1;
        req_valid = 2'b00; rsp_ready = 2'b00;
        req_opcode = '0; req_funct = '0; req_shamt = '0; req_imm = '0; req_rs = '0; req_rt = '0;
        @(negedge clk); #1;
        check("reset_rsp_valid", {30'h0, rsp_valid}, 32'd0);
        check("reset_busy", {31'h0, busy}, 32'd0);
        check("reset_result", rsp_result, 32'd0);
        check("reset_flags", {30'h0, rsp_branch, rsp_illegal}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        run_txn("add", 0, 6'h00, 6'h20, 5'd0, 16'd0, 32'd12, 32'hFFFF_FFF6, 0);
        run_txn("beq_eq", 1, 6'h04, 6'h00, 5'd0, 16'd0, 32'd4, 32'd4, 0);
        run_txn("beq_ne", 1, 6'h04, 6'h00, 5'd0, 16'd0, 32'd4, 32'd5, 0);
        run_txn("addi", 0, 6'h08, 6'h00, 5'd0, 16'd1500, 32'd15, 32'd0, 0);

        // Contention: both requesters continuously offering ORI.
        drive(0, 6'h13, 6'h00, 5'd0, 16'd1024, 32'd7, 32'd0);
        drive(1, 6'h13, 6'h00, 5'd0, 16'd1024, 32'd7, 32'd0);
        req_valid = 2'b11; rsp_ready = 2'b11;
        last_cyc = -1; ngrants = 0; last_g = 0;
        for (int c = 0; c < 24; c++) begin
            #1;
            if (req_ready != 2'b00) begin
                check("cont_grant", {30'h0, req_ready}, {30'h0, 2'b01 << exp_ptr});
                if (last_cyc >= 0) check("cont_interval", c - last_cyc, 32'd4);
                last_cyc = c; last_g = exp_ptr; exp_ptr = (exp_ptr + 1) % 2; ngrants++;
            end
            if (rsp_valid != 2'b00) begin
                check("cont_rsp_owner", {30'h0, rsp_valid}, {30'h0, 2'b01 << last_g});
                check("cont_result", rsp_result, 32'd1031);
            end
            @(negedge clk);
        end
        req_valid = 2'b00;
        check("cont_ngrants", ngrants, 32'd6);
        waited = 0;
        #1;
        while (busy && waited < 20) begin @(negedge clk); #1; waited++; end
        check("cont_drain", {31'h0, busy}, 32'd0);
        rsp_ready = 2'b00;
        @(negedge clk);

        run_txn("lw_bp", 0, 6'h23, 6'h00, 5'd0, 16'd1024, 32'hFFFF_FFF8, 32'd0, 5);
        run_txn("illegal", 1, 6'h00, 6'h3f, 5'd0, 16'd0, 32'd9, 32'd9, 0);

        for (int k = 0; k < 24; k++) begin
            op = ops[$urandom_range(0, 18)];
            fn = (op == 6'h00) ? fns[$urandom_range(0, 14)] : 6'($urandom);
            run_txn("rand", $urandom_range(0, 1), op, fn, 5'($urandom), 16'($urandom),
                    $urandom, ($urandom_range(0, 3) == 0) ? 32'd77 : $urandom, $urandom_range(0, 2));
        end

        // Reset while in CAPTURE aborts the transaction and rewinds the pointer.
        run_txn("pre_rst", 1, 6'h08, 6'h00, 5'd0, 16'd1500, 32'd15, 32'd0, 0);
        drive(0, 6'h08, 6'h00, 5'd0, 16'd1500, 32'd15, 32'd0);
        req_valid = 2'b01;
        #1;
        check("rst_pre_grant", {30'h0, req_ready}, 32'd1);
        @(negedge clk);
        req_valid = 2'b00;
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst_valid", {30'h0, rsp_valid}, 32'd0);
        check("rst_busy", {31'h0, busy}, 32'd0);
        check("rst_result", rsp_result, 32'd0);
        check("rst_flags", {30'h0, rsp_branch, rsp_illegal}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk); #1;
            check("rst_no_valid", {30'h0, rsp_valid}, 32'd0);
        end
        drive(1, 6'h08, 6'h00, 5'd0, 16'd2, 32'd3, 32'd0);
        req_valid = 2'b11;
        #1;
        check("rst_ptr_grant", {30'h0, req_ready}, 32'd1);
        @(negedge clk);
        req_valid = 2'b00;
        rsp_ready = 2'b11;
        waited = 0;
        #1;
        while (busy && waited < 20) begin @(negedge clk); #1; waited++; end
        check("rst_after_drain", {31'h0, busy}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
